// File: rtl/wb_data_port.sv
// Data-memory port: converts MEM-stage load/store requests into single
// Wishbone classic cycles. It checks alignment, places store data on the
// correct byte lanes, and extends load data to full width. Bus errors and
// timeouts are reported as faults.
module wb_data_port #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  input  logic                    req_we_i,
  input  logic [1:0]              req_size_i,
  input  logic                    req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  output logic                    busy_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rdata_valid_o,
  output logic                    fault_o,
  output logic [1:0]              fault_cause_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int SEL_W  = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(SEL_W);
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] CAUSE_ALIGN   = 2'b01;
  localparam logic [1:0] CAUSE_BUSERR  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_next_s;
  logic [1:0]          size_r;
  logic                unsigned_r;
  logic [LANE_W-1:0]   lane_r;
  logic [LANE_W-1:0]   lane_s;
  logic                aligned_s;
  logic [DATA_WIDTH-1:0] shifted_s;
  logic [DATA_WIDTH-1:0] load_ext_s;

  // Byte-enable pattern of an access size, anchored at lane 0.
  function automatic logic [SEL_W-1:0] size_mask(input logic [1:0] size);
    logic [SEL_W-1:0] m;
    case (size)
      2'b00:   m = SEL_W'(8'h01);
      2'b01:   m = SEL_W'(8'h03);
      2'b10:   m = SEL_W'(8'h0F);
      2'b11:   m = SEL_W'(8'hFF);
      default: m = SEL_W'(8'h00);
    endcase
    return m;
  endfunction

  // Expand a byte-enable mask into a per-bit data mask.
  function automatic logic [DATA_WIDTH-1:0] byte_bits(input logic [SEL_W-1:0] mask);
    logic [DATA_WIDTH-1:0] b;
    for (int i = 0; i < SEL_W; i++) begin
      b[8*i +: 8] = {8{mask[i]}};
    end
    return b;
  endfunction

  assign lane_s     = req_addr_i[LANE_W-1:0];
  assign cnt_next_s = cnt_r + CNT_W'(1);
  assign busy_o     = (state_r == ST_BUS) || (req_valid_i && aligned_s);

  // Size legality and natural-alignment check of the incoming request.
  always_comb begin
    aligned_s = 1'b0;
    case (req_size_i)
      2'b00:   aligned_s = 1'b1;
      2'b01:   aligned_s = (req_addr_i[0] == 1'b0);
      2'b10:   aligned_s = (req_addr_i[1:0] == 2'b00);
      2'b11:   aligned_s = (DATA_WIDTH == 64) && (req_addr_i[2:0] == 3'b000);
      default: aligned_s = 1'b0;
    endcase
  end

  // Right-align the addressed lane of the read data and extend it per size/signedness.
  always_comb begin
    shifted_s  = wb_dat_i >> {lane_r, 3'b000};
    load_ext_s = shifted_s;
    case (size_r)
      2'b00:   load_ext_s = unsigned_r ? DATA_WIDTH'(shifted_s[7:0])
                                       : DATA_WIDTH'($signed(shifted_s[7:0]));
      2'b01:   load_ext_s = unsigned_r ? DATA_WIDTH'(shifted_s[15:0])
                                       : DATA_WIDTH'($signed(shifted_s[15:0]));
      2'b10:   load_ext_s = unsigned_r ? DATA_WIDTH'(shifted_s[31:0])
                                       : DATA_WIDTH'($signed(shifted_s[31:0]));
      default: load_ext_s = shifted_s;
    endcase
  end

  // Access FSM: request capture, Wishbone cycle control, completion and fault reporting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      size_r        <= 2'b00;
      unsigned_r    <= 1'b0;
      lane_r        <= '0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      fault_o       <= 1'b0;
      fault_cause_o <= 2'b00;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_we_o       <= 1'b0;
      wb_adr_o      <= '0;
      wb_dat_o      <= '0;
      wb_sel_o      <= '0;
    end else begin
      rdata_valid_o <= 1'b0;
      fault_o       <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid_i && aligned_s) begin
            state_r    <= ST_BUS;
            cnt_r      <= '0;
            size_r     <= req_size_i;
            unsigned_r <= req_unsigned_i;
            lane_r     <= lane_s;
            wb_cyc_o   <= 1'b1;
            wb_stb_o   <= 1'b1;
            wb_we_o    <= req_we_i;
            wb_adr_o   <= req_addr_i;
            wb_sel_o   <= size_mask(req_size_i) << lane_s;
            wb_dat_o   <= (req_wdata_i & byte_bits(size_mask(req_size_i))) << {lane_s, 3'b000};
          end else if (req_valid_i) begin
            // Misaligned or illegal size: refuse without touching the bus.
            fault_o       <= 1'b1;
            fault_cause_o <= CAUSE_ALIGN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUS: begin
          if (wb_err_i) begin
            state_r       <= ST_IDLE;
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_we_o       <= 1'b0;
            fault_o       <= 1'b1;
            fault_cause_o <= CAUSE_BUSERR;
          end else if (wb_ack_i) begin
            state_r  <= ST_IDLE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            if (!wb_we_o) begin
              rdata_o       <= load_ext_s;
              rdata_valid_o <= 1'b1;
            end else begin
              rdata_valid_o <= 1'b0;
            end
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_next_s == TIMEOUT_VAL)) begin
            state_r       <= ST_IDLE;
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_we_o       <= 1'b0;
            fault_o       <= 1'b1;
            fault_cause_o <= CAUSE_TIMEOUT;
          end else begin
            cnt_r <= cnt_next_s;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_data_port.sv
// Directed bench for wb_data_port (32-bit bus, 8-cycle timeout).
// A simple Wishbone slave is driven inline; expected load results are
// queued at request time and popped when rdata_valid_o pulses.
module tb_wb_data_port;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        busy_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        fault_o;
  logic [1:0]  fault_cause_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  always #5 clk_i = ~clk_i;

  wb_data_port #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_valid_i(req_valid_i),
    .req_we_i(req_we_i),
    .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .busy_o(busy_o),
    .rdata_o(rdata_o),
    .rdata_valid_o(rdata_valid_o),
    .fault_o(fault_o),
    .fault_cause_o(fault_cause_o),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
  endtask

  // One accepted access; rsp: 0 = ack, 1 = err, 2 = ack+err. Response dly cycles after cyc.
  task automatic bus_access(input string tag, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                            input int dly, input int rsp, input logic [31:0] din,
                            input logic [3:0] exp_sel, input logic [31:0] exp_dat,
                            input logic [31:0] exp_rd);
    int  busy_n;
    logic exp_valid;
    drive_req(we, size, uns, addr, wdata);
    #1;
    chk({tag, "_busy_t0"}, 32'(busy_o), 32'd1);
    chk({tag, "_cyc_t0"}, 32'(wb_cyc_o), 32'd0);
    busy_n = 1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    exp_valid = (!we) && (rsp == 0);
    if (exp_valid) exp_q.push_back(exp_rd);
    chk({tag, "_cyc"}, 32'(wb_cyc_o), 32'd1);
    chk({tag, "_stb"}, 32'(wb_stb_o), 32'd1);
    chk({tag, "_we"}, 32'(wb_we_o), 32'(we));
    chk({tag, "_adr"}, wb_adr_o, addr);
    chk({tag, "_sel"}, 32'(wb_sel_o), 32'(exp_sel));
    chk({tag, "_dat"}, wb_dat_o, exp_dat);
    for (int i = 0; i < dly; i++) begin
      busy_n += (busy_o ? 1 : 0);
      @(posedge clk_i); #1;
    end
    wb_dat_i = din;
    wb_ack_i = (rsp != 1);
    wb_err_i = (rsp != 0);
    busy_n += (busy_o ? 1 : 0);
    chk({tag, "_cyc_hold"}, 32'(wb_cyc_o), 32'd1);
    chk({tag, "_sel_hold"}, 32'(wb_sel_o), 32'(exp_sel));
    @(posedge clk_i); #1;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    chk({tag, "_cyc_drop"}, 32'(wb_cyc_o), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy_o), 32'd0);
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(dly + 2));
    chk({tag, "_rvalid"}, 32'(rdata_valid_o), 32'(exp_valid));
    if (rdata_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
        last_rd = exp_q.pop_front();
        chk({tag, "_rdata"}, rdata_o, last_rd);
      end
    end else begin
      chk({tag, "_rdata_keep"}, rdata_o, last_rd);
    end
    chk({tag, "_fault"}, 32'(fault_o), 32'(rsp != 0));
    if (rsp != 0) chk({tag, "_cause"}, 32'(fault_cause_o), 32'd2);
  endtask

  // Request that must be refused: no bus cycle, fault pulse with cause 01.
  task automatic bad_access(input string tag, input logic [1:0] size, input logic [31:0] addr);
    drive_req(1'b0, size, 1'b0, addr, 32'h0);
    #1;
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    chk({tag, "_cyc"}, 32'(wb_cyc_o), 32'd0);
    chk({tag, "_fault"}, 32'(fault_o), 32'd1);
    chk({tag, "_cause"}, 32'(fault_cause_o), 32'd1);
    chk({tag, "_rdata_keep"}, rdata_o, last_rd);
    @(posedge clk_i); #1;
    chk({tag, "_fault_pulse"}, 32'(fault_o), 32'd0);
    chk({tag, "_cause_held"}, 32'(fault_cause_o), 32'd1);
    chk({tag, "_cyc_after"}, 32'(wb_cyc_o), 32'd0);
  endtask

  initial begin
    int n;
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = 32'h0; req_wdata_i = 32'h0;
    wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    last_rd = 32'h0;
    #12;
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_rvalid", 32'(rdata_valid_o), 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    chk("rst_cause", 32'(fault_cause_o), 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'd0);
    @(negedge clk_i); rst_i = 1'b0;
    @(posedge clk_i); #1;

    bus_access("ld_word", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 2, 0, 32'hDEADBEEF, 4'hF, 32'h0, 32'hDEADBEEF);
    bus_access("ld_sbyte", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 0, 32'h80112233, 4'h8, 32'h0, 32'hFFFFFF80);
    bus_access("ld_ubyte", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1, 0, 32'h80112233, 4'h8, 32'h0, 32'h00000080);
    bus_access("ld_shalf", 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 1, 0, 32'h80017777, 4'hC, 32'h0, 32'hFFFF8001);
    bus_access("st_half", 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 1, 0, 32'h0, 4'hC, 32'hABCD0000, 32'h0);
    bus_access("st_byte", 1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFFFF5A, 0, 0, 32'h0, 4'h2, 32'h00005A00, 32'h0);

    bad_access("mis_half", 2'b01, 32'h201);
    bus_access("ld_after_mis", 1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 0, 0, 32'h0BADF00D, 4'hF, 32'h0, 32'h0BADF00D);
    bad_access("mis_word", 2'b10, 32'h102);
    bad_access("ill_dword", 2'b11, 32'h200);

    // Timeout: no response, cycle must be held for exactly 8 BUS cycles.
    drive_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    n = 0;
    while (wb_cyc_o === 1'b1 && n < 50) begin
      n++;
      @(posedge clk_i); #1;
    end
    chk("to_cycles", 32'(n), 32'd8);
    chk("to_fault", 32'(fault_o), 32'd1);
    chk("to_cause", 32'(fault_cause_o), 32'd3);
    chk("to_busy", 32'(busy_o), 32'd0);
    chk("to_rdata_keep", rdata_o, last_rd);

    bus_access("ld_err", 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1, 1, 32'h55555555, 4'hF, 32'h0, 32'h0);
    bus_access("ld_ackerr", 1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 0, 2, 32'hAAAAAAAA, 4'hF, 32'h0, 32'h0);

    // Asynchronous reset in the middle of a bus cycle.
    drive_req(1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    chk("arst_cyc_before", 32'(wb_cyc_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("arst_stb", 32'(wb_stb_o), 32'd0);
    chk("arst_cause", 32'(fault_cause_o), 32'd0);
    chk("arst_rdata", rdata_o, 32'h0);
    last_rd = 32'h0;
    @(negedge clk_i); rst_i = 1'b0;
    @(posedge clk_i); #1;
    bus_access("ld_post_rst", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, 0, 32'h13579BDF, 4'hF, 32'h0, 32'h13579BDF);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
